// File: rtl/rv32_pkg.sv
// rv32_pkg: instruction formats, major opcodes and the canonical NOP shared by
// the encoder, its immediate packer and the program loader.
package rv32_pkg;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ISH = 3'd6,
      FMT_ILL = 3'd7
   } fmt_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Register/funct fields of a word for the given format; immediate bits and
   // the opcode are OR-ed in separately.
   function automatic logic [31:0] reg_fields(input fmt_t       fmt,
                                              input logic [6:0] funct7,
                                              input logic [4:0] rs2,
                                              input logic [4:0] rs1,
                                              input logic [2:0] funct3,
                                              input logic [4:0] rd);
      logic [31:0] w;
      w = '0;
      case (fmt)
         FMT_R:        w = {funct7, rs2, rs1, funct3, rd, 7'b0};
         FMT_I:        w = {12'b0, rs1, funct3, rd, 7'b0};
         FMT_S, FMT_B: w = {7'b0, rs2, rs1, funct3, 5'b0, 7'b0};
         FMT_U, FMT_J: w = {20'b0, rd, 7'b0};
         FMT_ISH:      w = {funct7, 5'b0, rs1, funct3, rd, 7'b0};
         default:      w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request channel, word/address output channel, address
// load and status of the instruction encoder. slave = encoder side.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 32
);
   import rv32_pkg::*;

   logic              in_valid;
   logic              in_ready;
   fmt_t              fmt;
   logic [6:0]        opcode;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [31:0]       imm;
   logic              addr_load;
   logic [ADDR_W-1:0] addr_base;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic [15:0]       enc_count;
   logic              enc_err;

   modport slave (
      input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
      input  addr_load, addr_base, out_ready,
      output in_ready, out_valid, out_instr, out_addr, enc_count, enc_err
   );

   modport master (
      output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
      output addr_load, addr_base, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, enc_count, enc_err
   );

endinterface

// File: rtl/imm_packer.sv
// imm_packer: scatters a signed immediate into its instruction bit positions
// for the given format and flags illegal requests.
// ENC_CHECK_EN defined: full range/alignment legality; otherwise only fmt=7.
module imm_packer
   import rv32_pkg::*;
(
   input  fmt_t        fmt,
   input  logic [31:0] imm,
   output logic [31:0] imm_field,
   output logic        illegal
);

   // Immediate bit-scatter; bits outside the format's fields are dropped.
   always_comb begin
      imm_field = '0;
      case (fmt)
         FMT_I: imm_field[31:20] = imm[11:0];
         FMT_S: begin
            imm_field[31:25] = imm[11:5];
            imm_field[11:7]  = imm[4:0];
         end
         FMT_B: begin
            imm_field[31]    = imm[12];
            imm_field[30:25] = imm[10:5];
            imm_field[11:8]  = imm[4:1];
            imm_field[7]     = imm[11];
         end
         FMT_U: imm_field[31:12] = imm[31:12];
         FMT_J: begin
            imm_field[31]    = imm[20];
            imm_field[30:21] = imm[10:1];
            imm_field[20]    = imm[11];
            imm_field[19:12] = imm[19:12];
         end
         FMT_ISH: imm_field[24:20] = imm[4:0];
         default: imm_field = '0;
      endcase
   end

`ifdef ENC_CHECK_EN
   logic signed [31:0] simm;
   assign simm = $signed(imm);

   // Legality: immediate must fit the format's signed field and alignment.
   always_comb begin
      illegal = 1'b0;
      case (fmt)
         FMT_I, FMT_S: illegal = (simm < -32'sd2048) || (simm > 32'sd2047);
         FMT_B:   illegal = imm[0] || (simm < -32'sd4096) || (simm > 32'sd4094);
         FMT_J:   illegal = imm[0] || (simm < -32'sd1048576) || (simm > 32'sd1048574);
         FMT_ISH: illegal = |imm[31:5];
         FMT_ILL: illegal = 1'b1;
         default: illegal = 1'b0;
      endcase
   end
`else
   // Without checking only the reserved format code is rejected.
   always_comb begin
      illegal = (fmt == FMT_ILL);
   end
`endif

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage valid/ready pipeline packing field requests into
// RV32 words with a running byte address (S1 = fields, S2 = word + address).
// ENC_CHECK_EN defined: illegal requests set the sticky enc_err flag.
module instr_encoder
   import rv32_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input logic         clk,
   input logic         rst_n,
   instr_encoder_if.slave bus
);

   logic              s1_valid;
   fmt_t              s1_fmt;
   logic [6:0]        s1_opcode;
   logic [4:0]        s1_rd;
   logic [4:0]        s1_rs1;
   logic [4:0]        s1_rs2;
   logic [2:0]        s1_funct3;
   logic [6:0]        s1_funct7;
   logic [31:0]       s1_imm;

   logic              out_valid_q;
   logic [31:0]       out_instr_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [15:0]       count_q;

   logic              in_ready;
   logic              in_fire;
   logic              s2_load;
   logic              out_fire;
   logic [31:0]       imm_field;
   logic              illegal;
   logic [31:0]       enc_word;

   assign in_ready = !s1_valid || !out_valid_q || bus.out_ready;
   assign in_fire  = bus.in_valid && in_ready;
   assign s2_load  = s1_valid && (!out_valid_q || bus.out_ready);
   assign out_fire = out_valid_q && bus.out_ready;

   imm_packer u_imm_packer (
      .fmt       (s1_fmt),
      .imm       (s1_imm),
      .imm_field (imm_field),
      .illegal   (illegal)
   );

   // Assemble the S1 request into a machine word; illegal requests become NOP.
   always_comb begin
      enc_word = reg_fields(s1_fmt, s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd)
               | imm_field | {25'b0, s1_opcode};
      if (illegal) enc_word = NOP_INSTR;
   end

   // S1: capture request fields; empties when its word moves into S2.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_fmt    <= FMT_R;
         s1_opcode <= '0;
         s1_rd     <= '0;
         s1_rs1    <= '0;
         s1_rs2    <= '0;
         s1_funct3 <= '0;
         s1_funct7 <= '0;
         s1_imm    <= '0;
      end else if (in_fire) begin
         s1_valid  <= 1'b1;
         s1_fmt    <= bus.fmt;
         s1_opcode <= bus.opcode;
         s1_rd     <= bus.rd;
         s1_rs1    <= bus.rs1;
         s1_rs2    <= bus.rs2;
         s1_funct3 <= bus.funct3;
         s1_funct7 <= bus.funct7;
         s1_imm    <= bus.imm;
      end else if (s2_load) begin
         s1_valid  <= 1'b0;
      end
   end

   // S2: hold the assembled word until the memory accepts it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_instr_q <= NOP_INSTR;
      end else if (s2_load) begin
         out_valid_q <= 1'b1;
         out_instr_q <= enc_word;
      end else if (out_fire) begin
         out_valid_q <= 1'b0;
      end
   end

   // Address counter: an explicit load overrides the post-handshake increment.
   always_ff @(posedge clk) begin
      if (!rst_n)             out_addr_q <= RESET_ADDR;
      else if (bus.addr_load) out_addr_q <= bus.addr_base;
      else if (out_fire)      out_addr_q <= out_addr_q + ADDR_W'(4);
   end

   // Emitted-word counter, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n)                        count_q <= '0;
      else if (out_fire && count_q != '1) count_q <= count_q + 16'd1;
   end

`ifdef ENC_CHECK_EN
   logic err_q;

   // Sticky error: set when an illegal request leaves S1, cleared by reset only.
   always_ff @(posedge clk) begin
      if (!rst_n)                  err_q <= 1'b0;
      else if (s2_load && illegal) err_q <= 1'b1;
   end

   assign bus.enc_err = err_q;
`else
   assign bus.enc_err = 1'b0;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.enc_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector table plus hand-written sequences for
// backpressure, address load/wrap, error flag and mid-stream reset.
module tb_instr_encoder;
   import rv32_pkg::*;

`ifdef ENC_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      string       name;
      fmt_t        fmt;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   logic clk;
   logic rst_n;
   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;
   vec_t vecs[12];

   instr_encoder_if #(.ADDR_W(32)) bus ();

   instr_encoder #(.ADDR_W(32), .RESET_ADDR(32'h0000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else pass_cnt++;
   endtask

   function automatic vec_t mk(input string name, input fmt_t fmt, input logic [6:0] op,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                               input logic [31:0] exp_instr, input logic exp_err);
      vec_t v;
      v.name = name; v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_instr = exp_instr; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.addr_load = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Present a request and hold it until accepted (bounded).
   task automatic send(input vec_t v);
      int unsigned n;
      logic acc;
      bus.fmt = v.fmt; bus.opcode = v.op; bus.rd = v.rd; bus.rs1 = v.rs1;
      bus.rs2 = v.rs2; bus.funct3 = v.f3; bus.funct7 = v.f7; bus.imm = v.imm;
      bus.in_valid = 1'b1;
      n = 0; acc = 1'b0;
      while (!acc && n < 50) begin
         @(negedge clk); acc = bus.in_ready;
         @(posedge clk); #1;
         n++;
      end
      bus.in_valid = 1'b0;
      chk({v.name, "_accept"}, 32'(acc), 32'd1);
   endtask

   // Wait (bounded) for a word in S2 and compare it; does not consume it.
   task automatic wait_out(input string name, input logic [31:0] exp_instr, input logic [31:0] exp_addr);
      int unsigned n;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_instr"}, bus.out_instr, exp_instr);
      chk({name, "_addr"}, bus.out_addr, exp_addr);
   endtask

   function automatic vec_t rvec(input string name, input logic [4:0] rd);
      return mk(name, FMT_R, OP_R, rd, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,
                32'h0031_0033 | (32'(rd) << 7), 1'b0);
   endfunction

   initial begin
      vec_t v;
      logic [31:0] got_i[5];
      logic [31:0] got_a[5];
      int unsigned got;
      logic saw_low;
      logic seen;

      vecs[0]  = mk("r_add",     FMT_R,   OP_R,      5'd1,  5'd2,  5'd3,  3'd0, 7'd0,       32'd0,        32'h003100B3, 1'b0);
      vecs[1]  = mk("beq",       FMT_B,   OP_BRANCH, 5'd0,  5'd17, 5'd18, 3'd0, 7'd0,       32'd8,        32'h01288463, 1'b0);
      vecs[2]  = mk("jal",       FMT_J,   OP_JAL,    5'd1,  5'd0,  5'd0,  3'd0, 7'd0,       32'd100,      32'h064000EF, 1'b0);
      vecs[3]  = mk("lui",       FMT_U,   OP_LUI,    5'd4,  5'd0,  5'd0,  3'd0, 7'd0,       32'h12345000, 32'h12345237, 1'b0);
      vecs[4]  = mk("addi_neg",  FMT_I,   OP_IMM,    5'd5,  5'd6,  5'd0,  3'd0, 7'd0,       32'hFFFFFFFF, 32'hFFF30293, 1'b0);
      vecs[5]  = mk("sw",        FMT_S,   OP_STORE,  5'd0,  5'd8,  5'd7,  3'd2, 7'd0,       32'd12,       32'h00742623, 1'b0);
      vecs[6]  = mk("srai",      FMT_ISH, OP_IMM,    5'd9,  5'd10, 5'd0,  3'd5, 7'b0100000, 32'd3,        32'h40355493, 1'b0);
      vecs[7]  = mk("bne_neg",   FMT_B,   OP_BRANCH, 5'd0,  5'd1,  5'd2,  3'd1, 7'd0,       32'hFFFFFFFC, 32'hFE209EE3, 1'b0);
      vecs[8]  = mk("jal_neg",   FMT_J,   OP_JAL,    5'd0,  5'd0,  5'd0,  3'd0, 7'd0,       32'hFFFFFFF8, 32'hFF9FF06F, 1'b0);
      vecs[9]  = mk("lui_trunc", FMT_U,   OP_LUI,    5'd4,  5'd0,  5'd0,  3'd0, 7'd0,       32'h12345FFF, 32'h12345237, 1'b0);
      vecs[10] = mk("fmt_ill",   FMT_ILL, OP_R,      5'd1,  5'd2,  5'd3,  3'd0, 7'd0,       32'd0,        32'h00000013, CHK);
      vecs[11] = mk("addi_big",  FMT_I,   OP_IMM,    5'd1,  5'd0,  5'd0,  3'd0, 7'd0,       32'h00001005,
                    CHK ? 32'h00000013 : 32'h00500093, CHK);

      bus.in_valid = 1'b0; bus.fmt = FMT_R; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0;
      bus.rs2 = '0; bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
      bus.addr_load = 1'b0; bus.addr_base = '0; bus.out_ready = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      do_reset();

      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_instr", bus.out_instr, 32'h00000013);
      chk("rst_out_addr",  bus.out_addr,  32'h0);
      chk("rst_enc_count", 32'(bus.enc_count), 32'd0);
      chk("rst_enc_err",   32'(bus.enc_err), 32'd0);

      // Vector table, one word at a time with out_ready high.
      for (int i = 0; i < 12; i++) begin
         send(vecs[i]);
         if (i == 0) begin
            chk("lat_after_accept", 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
            chk("lat_next_edge", 32'(bus.out_valid), 32'd1);
         end
         wait_out(vecs[i].name, vecs[i].exp_instr, 32'(4 * i));
         chk({vecs[i].name, "_err"}, 32'(bus.enc_err), 32'(vecs[i].exp_err));
         @(posedge clk); #1;
      end
      chk("table_count", 32'(bus.enc_count), 32'd12);

      // Backpressure: 5 back-to-back requests, out_ready low for 3 cycles.
      do_reset();
      got = 0; saw_low = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) send(rvec("bp", 5'(i + 1)));
         end
         begin
            for (int c = 0; c < 30; c++) begin
               bus.out_ready = !(c >= 4 && c < 7);
               @(negedge clk);
               if (!bus.in_ready) saw_low = 1'b1;
               if (bus.out_valid && bus.out_ready) begin
                  if (got < 5) begin
                     got_i[got] = bus.out_instr;
                     got_a[got] = bus.out_addr;
                  end
                  got++;
               end
               @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      chk("bp_in_ready_dropped", 32'(saw_low), 32'd1);
      chk("bp_word_count", got, 32'd5);
      for (int k = 0; k < 5; k++) begin
         chk("bp_instr", got_i[k], 32'h0031_0033 | (32'(k + 1) << 7));
         chk("bp_addr",  got_a[k], 32'(4 * k));
      end
      chk("bp_enc_count", 32'(bus.enc_count), 32'd5);

      // Address load and wrap.
      bus.addr_load = 1'b1; bus.addr_base = 32'hFFFF_FFFC;
      @(posedge clk); #1;
      bus.addr_load = 1'b0;
      chk("load_addr", bus.out_addr, 32'hFFFF_FFFC);
      send(rvec("wrap0", 5'd1));
      wait_out("wrap0", 32'h003100B3, 32'hFFFF_FFFC);
      @(posedge clk); #1;
      send(rvec("wrap1", 5'd2));
      wait_out("wrap1", 32'h00310133, 32'h0000_0000);
      @(posedge clk); #1;
      send(rvec("ldhs", 5'd3));
      wait_out("ldhs", 32'h003101B3, 32'h0000_0004);
      bus.addr_load = 1'b1; bus.addr_base = 32'h0000_0100;
      @(posedge clk); #1;
      bus.addr_load = 1'b0;
      chk("ldhs_addr_wins", bus.out_addr, 32'h0000_0100);
      chk("ldhs_consumed", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;
      send(rvec("held", 5'd4));
      wait_out("held", 32'h00310233, 32'h0000_0100);
      bus.addr_load = 1'b1; bus.addr_base = 32'h0000_2000;
      @(posedge clk); #1;
      bus.addr_load = 1'b0;
      chk("held_valid", 32'(bus.out_valid), 32'd1);
      chk("held_instr", bus.out_instr, 32'h00310233);
      chk("held_addr",  bus.out_addr, 32'h0000_2000);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("held_addr_after", bus.out_addr, 32'h0000_2004);
      chk("held_drained", 32'(bus.out_valid), 32'd0);

      // Misaligned branch offset and sticky error flag.
      do_reset();
      chk("err_clear", 32'(bus.enc_err), 32'd0);
      send(mk("b_odd", FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'd0, 1'b0));
      wait_out("b_odd", CHK ? 32'h00000013 : 32'h00000363, 32'h0);
      chk("b_odd_err", 32'(bus.enc_err), 32'(CHK));
      @(posedge clk); #1;
      send(rvec("after_err", 5'd1));
      wait_out("after_err", 32'h003100B3, 32'h4);
      chk("err_sticky", 32'(bus.enc_err), 32'(CHK));
      @(posedge clk); #1;

      // Reset with both stages full.
      bus.out_ready = 1'b0;
      send(rvec("mid_a", 5'd5));
      wait_out("mid_a", 32'h003102B3, 32'h8);
      send(rvec("mid_b", 5'd6));
      chk("mid_full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("mid_count_before", 32'(bus.enc_count), 32'd2);
      do_reset();
      chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_enc_count", 32'(bus.enc_count), 32'd0);
      chk("mid_out_addr",  bus.out_addr, 32'h0);
      chk("mid_enc_err",   32'(bus.enc_err), 32'd0);
      bus.out_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("mid_nothing_emitted", 32'(seen), 32'd0);
      chk("mid_count_after", 32'(bus.enc_count), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
